// File: rtl/popcount_8b_pattern_gen.sv
// Streaming enumerator: for a requested popcount k, emits every 8-bit pattern with
// min(k, 8) ones in ascending order over a val/rdy stream.
module popcount_8b_pattern_gen (
  input  logic       clk,
  input  logic       reset,
  input  logic       istream_val,
  output logic       istream_rdy,
  input  logic [3:0] istream_msg,
  output logic       ostream_val,
  input  logic       ostream_rdy,
  output logic [7:0] ostream_msg,
  output logic       ostream_last
);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e      state_q;
  logic [7:0]  pattern_q;
  logic [7:0]  top_q;

  logic [3:0]  keff;
  logic [15:0] init_w;
  logic [15:0] top_w;
  logic [7:0]  lsb;
  logic [7:0]  ripple;
  logic [7:0]  spread;
  logic [7:0]  succ;
  logic [2:0]  ctz;
  logic        at_top;

  // First and final patterns of the burst for the clamped request count.
  always_comb begin
    keff   = (istream_msg > 4'd8) ? 4'd8 : istream_msg;
    init_w = (16'd1 << keff) - 16'd1;
    top_w  = init_w << (4'd8 - keff);
  end

  // Gosper successor: next larger value with the same number of set bits.
  always_comb begin
    lsb    = pattern_q & (~pattern_q + 8'd1);
    ripple = pattern_q + lsb;
    ctz    = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (lsb[i]) ctz = 3'(i);
    end
    spread = ((ripple ^ pattern_q) >> 2) >> ctz;
    succ   = ripple | spread;
  end

  assign at_top = (pattern_q == top_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      pattern_q <= 8'h00;
      top_q     <= 8'h00;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (istream_val) begin
            pattern_q <= init_w[7:0];
            top_q     <= top_w[7:0];
            state_q   <= StEmit;
          end
        end
        StEmit: begin
          if (ostream_rdy) begin
            if (at_top) state_q   <= StIdle;
            else        pattern_q <= succ;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign istream_rdy  = (state_q == StIdle);
  assign ostream_val  = (state_q == StEmit);
  assign ostream_msg  = pattern_q;
  assign ostream_last = (state_q == StEmit) && at_top;

endmodule

// File: doc/popcount_8b_pattern_gen.md
# popcount_8b_pattern_gen

Streaming inverse of the 8-bit population-count unit. It accepts a count k and emits, one per cycle, every 8-bit pattern whose popcount equals k, in ascending numeric order. It is the stimulus/enumeration companion to the combinational popcount block: feeding its output into that block must return k for every pattern. It uses val/rdy streams on both sides.

## Interface
- Parameters: none; data width fixed at 8 bits, count width fixed at 4 bits.
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- istream_val  input  1  count request valid
- istream_rdy  output  1  block can accept a count
- istream_msg  input  4  requested popcount k (0..15)
- ostream_val  output  1  pattern valid
- ostream_rdy  input  1  consumer accepts pattern
- ostream_msg  output  8  current pattern
- ostream_last  output  1  high with the final pattern of the current burst

## Operation
- Two states: IDLE and EMIT. Reset forces IDLE.
- IDLE:
  - istream_rdy=1, ostream_val=0, ostream_last=0.
  - Request transfer when istream_val && istream_rdy.
  - On transfer, latch keff = min(k, 8); pattern register ← (1<<keff)-1; go to EMIT.
  - k values 9..15 clamp to 8 (single pattern 0xFF).
- EMIT:
  - istream_rdy=0 (no request overlap), ostream_val=1, ostream_msg=pattern register.
  - ostream_last=1 iff pattern equals the top-aligned value ((1<<keff)-1)<<(8-keff). For keff=0 this is 0x00; for keff=8 it is 0xFF.
  - On output transfer (ostream_val && ostream_rdy):
    - if ostream_last → IDLE;
    - else pattern ← next larger 8-bit value with the same popcount (Gosper successor: c = x & -x, r = x + c, next = r | (((r ^ x) >> 2) >> ctz(c))).
  - Without a transfer, pattern and ostream_last hold stable.
- Burst lengths equal C(8,keff): k=0..8 gives 1, 8, 28, 56, 70, 56, 28, 8, 1.
- Every emitted pattern is distinct, strictly increasing, and has popcount keff.
- All arithmetic is on 8 bits. The successor is never computed from the last pattern, so overflow cannot occur.
- Reset mid-burst aborts immediately:
  - no further outputs;
  - the next request starts a fresh burst.

## Timing
- Reset values: istream_rdy=1, ostream_val=0, ostream_msg=0x00, ostream_last=0, state=IDLE, pattern=0x00.
- Latency: request accepted at edge t → first pattern valid in the cycle after edge t.
- Throughput: one pattern per cycle while ostream_rdy=1.
  - A full burst of N patterns occupies N cycles in EMIT.
- After the last transfer at edge t, istream_rdy=1 in the cycle after edge t. A new request can be accepted at edge t+1.
  - There is one dead cycle between bursts on ostream.
- ostream_rdy may toggle arbitrarily. ostream_msg and ostream_last must not change while ostream_val=1 && ostream_rdy=0.
- istream_val asserted during EMIT is ignored; the request is held by the producer until IDLE.
- All outputs are driven from registers plus state decode; there is no combinational path from ostream_rdy or istream_val to any output.

## Test plan
- Reset, then k=0 with ostream_rdy=1:
  - exactly one output 0x00 with last=1, first output one cycle after acceptance;
  - istream_rdy returns to 1 the next cycle.
- k=1, ostream_rdy=1:
  - 8 consecutive outputs 0x01, 0x02, 0x04 … 0x80;
  - last=1 only on 0x80.
- k=2 with random ostream_rdy backpressure:
  - 28 outputs 0x03, 0x05, 0x06, 0x09 … 0xC0, no duplicates or drops;
  - msg/last stable while stalled.
- k=4:
  - 70 outputs, each with popcount 4 (checked through the popcount block), strictly ascending from 0x0F to 0xF0.
- k=8 and k=12:
  - each yields a single output 0xFF with last=1.
  - istream_val held high during the burst is not accepted until IDLE.
- Reset asserted asynchronously mid-burst of k=3 (after the 10th pattern):
  - ostream_val drops to 0 immediately and istream_rdy=1;
  - a subsequent k=3 request restarts at 0x07.
